// File: rtl/fb_writer.sv
// ---------------------------------------------------------------------------
// fb_writer -- raster pixel stream to split-panel frame buffer writer
//
// Takes a valid/ready stream of 24-bit RGB pixels in raster order and turns
// it into write strobes for two RAMs. RAM0 holds the upper 32 panel rows and
// RAM1 holds the lower 32 rows. A 12-bit pixel counter walks the whole
// 64x64 frame. Its MSB selects the RAM, and its low 11 bits form the
// in-RAM address.
//
// Ports
//   i_clk          system clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   i_valid        pixel beat valid
//   o_ready        writer can accept a beat (low in reset and in DONE)
//   i_data[23:0]   pixel {R,G,B}
//   i_sof          start of frame, marks pixel (0,0)
//   o_we0          write strobe, upper-half RAM
//   o_we1          write strobe, lower-half RAM
//   o_waddr[11:0]  {bank, x + (y mod 32)*64}
//   o_wdata[23:0]  pixel data to RAM
//   o_frame_done   one-cycle pulse with the strobe of the last frame pixel
//   o_sync_err     one-cycle pulse when i_sof arrives inside a frame
//   o_rd_bank      bank the display reader shall use
//
// Build option
//   FB_DOUBLE_BUFFER_EN  when defined, a write-bank register drives
//                        o_waddr[11]. The write bank and o_rd_bank flip
//                        together on each frame completion. When the macro is
//                        undefined, both are tied to 0 (single buffer).
// ---------------------------------------------------------------------------
module fb_writer #(
  parameter int HORIZONTAL_LENGTH = 64,
  parameter int VERTICAL_LENGTH   = 64
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [23:0] i_data,
  input  logic        i_sof,
  output logic        o_we0,
  output logic        o_we1,
  output logic [11:0] o_waddr,
  output logic [23:0] o_wdata,
  output logic        o_frame_done,
  output logic        o_sync_err,
  output logic        o_rd_bank
);

  localparam int          DATA_W   = 24;
  localparam int          CNT_W    = 12;
  localparam logic [11:0] LAST_PIX = 12'(HORIZONTAL_LENGTH * VERTICAL_LENGTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ready;
  logic                r_we0;
  logic                r_we1;
  logic [11:0]         r_waddr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_frame_done;
  logic                r_sync_err;
  logic                r_wbank;
  logic                r_rd_bank;

  logic                w_accept;
  logic                w_last;
  logic                w_bank;

  assign w_accept = i_valid & r_ready;
  assign w_last   = (r_cnt == LAST_PIX);

`ifdef FB_DOUBLE_BUFFER_EN
  assign w_bank = r_wbank;
`else
  assign w_bank = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_ready      <= 1'b0;
      r_we0        <= 1'b0;
      r_we1        <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      r_wbank      <= 1'b0;
      r_rd_bank    <= 1'b0;
    end else begin
      // Strobes and pulses default low so that a cycle without an accepted
      // beat never writes.
      r_we0        <= 1'b0;
      r_we1        <= 1'b0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          // Ready comes up on the first clock after reset release.
          r_ready <= 1'b1;
          // Beats without i_sof are consumed and dropped while waiting for
          // the start of a frame.
          if (w_accept && i_sof) begin
            r_we0   <= 1'b1;
            r_waddr <= {w_bank, 11'd0};
            r_wdata <= i_data;
            r_cnt   <= 12'd1;
            r_state <= S_WRITE;
          end
        end

        S_WRITE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_wdata <= i_data;
            if (i_sof) begin
              // An i_sof inside a frame restarts the frame. This takes
              // precedence over the last-pixel check, so an i_sof at
              // position 4095 is a resync and not a frame end.
              r_sync_err <= 1'b1;
              r_we0      <= 1'b1;
              r_waddr    <= {w_bank, 11'd0};
              r_cnt      <= 12'd1;
            end else begin
              r_we0   <= ~r_cnt[11];
              r_we1   <= r_cnt[11];
              r_waddr <= {w_bank, r_cnt[10:0]};
              if (w_last) begin
                // Drop ready during the DONE cycle. The counter is
                // cleared there.
                r_frame_done <= 1'b1;
                r_ready      <= 1'b0;
                r_state      <= S_DONE;
              end else begin
                r_cnt <= r_cnt + 12'd1;
              end
            end
          end
        end

        S_DONE: begin
          r_ready <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_IDLE;
`ifdef FB_DOUBLE_BUFFER_EN
          // Swap buffers once the frame is complete. The next frame goes to
          // the other bank.
          r_wbank   <= ~r_wbank;
          r_rd_bank <= ~r_rd_bank;
`endif
        end

        default: begin
          r_ready <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ready      = r_ready;
  assign o_we0        = r_we0;
  assign o_we1        = r_we1;
  assign o_waddr      = r_waddr;
  assign o_wdata      = r_wdata;
  assign o_frame_done = r_frame_done;
  assign o_sync_err   = r_sync_err;

`ifdef FB_DOUBLE_BUFFER_EN
  assign o_rd_bank = r_rd_bank;
`else
  assign o_rd_bank = 1'b0;
`endif

endmodule
